// File: rtl/audio_nios_key_pio.sv
// Push-button input port: per-bit sync + debounce, edge capture with W1C clear,
// maskable level irq. Zero-wait-state Avalon-MM reads on a 2-bit word map.

module audio_nios_key_pio_lane #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic stable_o,
    output logic stable_prev_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter restarts on any agreement, so only an unbroken run of
    // DEBOUNCE_CYCLES mismatches moves the stable value.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= IDLE_LEVEL;
            sync2_q       <= IDLE_LEVEL;
            stable_q      <= IDLE_LEVEL;
            stable_prev_q <= IDLE_LEVEL;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= in_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_prev_o = stable_prev_q;
endmodule

module audio_nios_key_pio #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] stable, stable_prev;
    logic [WIDTH-1:0] rise, fall, edge_hit;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic             wr_en;
    logic             unused_wd;

    genvar g;
    for (g = 0; g < WIDTH; g++) begin : g_lane
        audio_nios_key_pio_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_lane (
            .clk           (clk),
            .reset_n       (reset_n),
            .in_i          (in_port[g]),
            .stable_o      (stable[g]),
            .stable_prev_o (stable_prev[g])
        );
    end

    assign rise  = stable & ~stable_prev;
    assign fall  = ~stable & stable_prev;
    assign wr_en = chipselect && !write_n;
    assign unused_wd = ^writedata;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
    end

    // OR-ing the edge in after the clear lets a new edge win over a W1C.
    always_comb begin
        irq_mask_d = irq_mask_q;
        capture_d  = capture_q;
        if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3) capture_d = capture_q & ~writedata[WIDTH-1:0];
        capture_d = capture_d | edge_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            capture_q  <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata[WIDTH-1:0] = capture_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(capture_q & irq_mask_q);
endmodule

// File: doc/audio_nios_key_pio.md
# audio_nios_key_pio

Avalon-MM slave input port for the audio Nios subsystem: samples the board push-buttons, synchronises and debounces each bit, latches selected edges in a software-clearable edge-capture register and raises a maskable level interrupt. It is the input-direction counterpart of the LED output port and shares its 2-bit word address map and zero-wait-state read timing.

## Interface
- WIDTH, 4: number of input bits (1–32).
- DEBOUNCE_CYCLES, 500000: consecutive mismatching clocks before a bit's debounced value changes (10 ms at 50 MHz); minimum 1.
- EDGE_TYPE, 1: edges captured: 0 rising, 1 falling, 2 both.
- IDLE_LEVEL, 1: reset value of the synchroniser and debounced registers (all bits).
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous button inputs.
- readdata  output  32  read data, combinational from address.
- irq  output  1  level interrupt, active high.

## Operation
- Register map (word addresses):
  - 0 DATA, RO: debounced value in bits [WIDTH-1:0]; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQ_MASK, RW: bit i enables edge-capture bit i onto irq.
  - 3 EDGE_CAPTURE, R/W1C: bit i set on qualifying edge of debounced bit i; writing 1 to bit i clears it, writing 0 leaves it.
- Unused upper readdata bits read 0. Write = chipselect && !write_n; writedata bits above WIDTH-1 ignored.
- Synchroniser: two flops per bit, sync1 <= in_port, sync2 <= sync1.
- Debounce, per bit, independent counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1):
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - mismatch and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - mismatch and cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i], cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES clocks at sync2 never changes stable; any return to agreement restarts the count.
- Edge detect: stable_d <= stable; rise = stable & ~stable_d; fall = ~stable & stable_d; qualifying edge per EDGE_TYPE.
- EDGE_CAPTURE next = (capture & ~clear_mask) | edge; set wins over simultaneous W1C on the same bit.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.

## Timing
- Reset (asynchronous assert, synchronous-clock release): sync1, sync2, stable, stable_d = {WIDTH{IDLE_LEVEL}}; cnt = 0; IRQ_MASK = 0; EDGE_CAPTURE = 0; irq = 0; readdata reflects reset state (DATA = IDLE_LEVEL bits). No edge is generated by reset release.
- Reset asserted mid-debounce discards partial counts; mid-capture clears pending bits and irq immediately.
- Read latency 0: readdata valid in the same cycle as address/chipselect, no wait states.
- Write takes effect at the clock edge where the write is sampled; new IRQ_MASK/EDGE_CAPTURE visible on readdata and irq the following cycle.
- in_port step sampled at edge 1: sync2 changes at edge 2; stable changes at edge 2+DEBOUNCE_CYCLES; EDGE_CAPTURE bit and irq rise at edge 3+DEBOUNCE_CYCLES. Exact, no tolerance.
- DEBOUNCE_CYCLES = 1: stable follows sync2 one clock later.
- Counter never wraps: saturates by construction at DEBOUNCE_CYCLES-1 before update.

## Test plan
- Reset/readback (WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1, in_port=4'hF): after reset, read addr 0 -> 0x0000000F, addr 1/2/3 -> 0, irq=0; write 0xFFFFFFFF to addr 0 -> still 0x0000000F.
- Debounce latency: in_port 4'hF->4'hE sampled at edge 1 -> DATA reads 0xE from edge 6, EDGE_CAPTURE = 0x1 from edge 7; 3-clock low pulse on bit 1 -> DATA and EDGE_CAPTURE unchanged.
- Edge type: EDGE_TYPE=1, press and release bit 0 -> only press captured (0x1); EDGE_TYPE=0 -> only release; EDGE_TYPE=2 -> both, capture stays 0x1 until cleared.
- Interrupt mask: capture=0x1, IRQ_MASK=0 -> irq=0; write 0x1 to addr 2 -> irq=1 next cycle; write 0x1 to addr 3 -> capture 0, irq=0 next cycle; write 0x0 to addr 3 -> no change.
- Simultaneous set/clear: W1C of bit 2 in same cycle as new bit-2 edge -> bit 2 remains 1; W1C 0x3 with bits 0,1,2 set -> reads 0x4.
- Reset mid-operation: assert reset_n low two clocks into a debounce with capture=0x8, IRQ_MASK=0xF -> irq drops immediately, all registers at reset values, no capture after release with in_port stable at 4'hF.
